// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the EX-stage multi-cycle multiplier and divider:
// launches one MULT/MULTU/DIV/DIVU at a time, stalls EX, and returns HI/LO write data.
module muldiv_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        ex_accept,
    input  logic        flush,
    output logic        mul_start,
    output logic        div_start,
    output logic        mul_signed,
    output logic        div_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        mul_annul,
    output logic        div_annul,
    input  logic        mul_ready,
    input  logic        div_ready,
    input  logic [63:0] mul_result,
    input  logic [63:0] div_result,
    output logic        stallreq,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        timeout_err,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [1:0]     op_q;
    logic [31:0]    src1_q, src2_q;
    logic [31:0]    hi_q, lo_q;
    logic [CW-1:0]  cnt;
    logic           err_q;

    logic           lat_en, cap_en, cnt_clr, cnt_inc, err_set, annul;
    logic [63:0]    cap_val;
    logic           is_div, in_busy, unit_ready;
    logic [63:0]    unit_result;

    assign is_div      = op_q[1];
    assign in_busy     = (state == S_BUSY);
    assign unit_ready  = is_div ? div_ready  : mul_ready;
    assign unit_result = is_div ? div_result : mul_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= 2'b00;
            src1_q <= '0;
            src2_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (lat_en) begin
                op_q   <= req_op;
                src1_q <= req_src1;
                src2_q <= req_src2;
            end
            if (cap_en) begin
                hi_q <= cap_val[63:32];
                lo_q <= cap_val[31:0];
            end
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (err_set)      err_q <= 1'b1;
        end
    end

    // flush overrides every other event in the same cycle, so it is tested first in BUSY
    always_comb begin
        state_n = state;
        lat_en  = 1'b0;
        cap_en  = 1'b0;
        cap_val = '0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        err_set = 1'b0;
        annul   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    lat_en = 1'b1;
                    if (req_op[1] && (req_src2 == 32'd0)) begin
                        cap_en  = 1'b1;
                        cap_val = {req_src1, 32'hFFFF_FFFF};
                        state_n = S_DONE;
                    end else begin
                        cnt_clr = 1'b1;
                        state_n = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    annul   = 1'b1;
                    state_n = S_IDLE;
                end else if (unit_ready) begin
                    cap_en  = 1'b1;
                    cap_val = unit_result;
                    state_n = S_DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    annul   = 1'b1;
                    err_set = 1'b1;
                    cap_en  = 1'b1;
                    cap_val = '0;
                    state_n = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DONE: begin
                if (flush || ex_accept) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Handshake: start is a level held through BUSY; ready is sampled only while BUSY and
    // completes the operation in that cycle; annul is a single-cycle abort of the active unit.
    assign mul_start   = in_busy & ~is_div;
    assign div_start   = in_busy &  is_div;
    assign mul_signed  = in_busy & ~is_div & ~op_q[0];
    assign div_signed  = in_busy &  is_div & ~op_q[0];
    assign mul_a       = is_div ? 32'd0 : src1_q;
    assign mul_b       = is_div ? 32'd0 : src2_q;
    assign div_a       = is_div ? src1_q : 32'd0;
    assign div_b       = is_div ? src2_q : 32'd0;
    assign mul_annul   = annul & ~is_div;
    assign div_annul   = annul &  is_div;

    assign stallreq    = req_valid & (((state == S_IDLE) & ~flush) | in_busy);
    assign hi_we       = (state == S_DONE) & ~flush;
    assign lo_we       = hi_we;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign busy        = (state != S_IDLE);
    assign timeout_err = err_q;
    assign dbg_state   = state;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the multi-cycle multiplier and divider used by the EX stage. It accepts one MULT/MULTU/DIV/DIVU operation at a time and launches the matching unit with latched operands. While the operation is in flight it holds the pipeline stall request, then captures the 64-bit result and presents HI/LO write data. It also handles divide-by-zero bypass, flush annulment and a hang watchdog.

## Interface
- TIMEOUT, 64: maximum BUSY cycles before the watchdog aborts (≥ 40).
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  EX holds a mul/div instruction. Held level for as long as EX is stalled.
- req_op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- req_src1, req_src2  in  32  operands: rs, rt.
- ex_accept  in  1  EX register advances this cycle (stall[2] not asserted).
- flush  in  1  discard the current operation.
- mul_start, div_start  out  1  level start to each unit.
- mul_signed, div_signed  out  1  signed-operation select to each unit.
- mul_a, mul_b, div_a, div_b  out  32  operands, driven from internal latches.
- mul_annul, div_annul  out  1  one-cycle abort pulse.
- mul_ready, div_ready  in  1  unit result valid.
- mul_result, div_result  in  64  unit results: {hi,lo}; for div, {remainder,quotient}.
- stallreq  out  1  stall request to the hazard/stall controller.
- hi_we, lo_we  out  1  HI/LO write enables.
- hi_out, lo_out  out  32  HI/LO write data.
- busy  out  1  state is not IDLE.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, req_valid=1, no flush:
  - Latch op, src1 and src2.
  - If the op is DIV/DIVU and src2==0, go to DONE with hi=src1, lo=32'hFFFF_FFFF. The divider is not started.
  - Otherwise go to BUSY and clear the cycle counter.
- BUSY:
  - Assert the selected unit's start. Signed = op[0]==0. Operands come from the latches; the other unit's outputs are all zero.
  - On the selected unit's ready=1, capture its result into hi/lo and go to DONE. Start drops in DONE.
  - The cycle counter increments every BUSY cycle. At count==TIMEOUT-1 without ready: pulse that unit's annul, set timeout_err, hi=lo=0, go to DONE.
- DONE:
  - hi_out/lo_out = captured values. hi_we=lo_we=1.
  - On ex_accept=1, go to IDLE. This consumes the result exactly once.
- stallreq = req_valid & ((IDLE & no flush) | BUSY). It is combinational so EX cannot advance in the launch cycle. It is 0 in DONE.
- flush in any state:
  - Next state IDLE.
  - If in BUSY, pulse the active unit's annul for that cycle.
  - hi_we/lo_we = 0 in that cycle. Nothing is latched.
  - flush wins over ready, timeout and req_valid arriving in the same cycle.
- req_valid falling in BUSY without flush is a protocol error. The operation still completes.
- rst:
  - state IDLE, latches 0, counter 0, timeout_err 0.
  - All outputs 0, except stallreq, which follows its formula (0 when req_valid=0).
  - Units are reset by the same rst; no annul is pulsed.

## Timing
- Cycle N: req_valid seen in IDLE, stallreq=1 combinationally, state→BUSY at edge N.
- Cycle N+1 onward: start=1. Ready seen at cycle N+k → DONE at N+k+1 with hi_we=1 and stallreq=0. EX advances at the end of cycle N+k+1.
- Total added latency: unit latency + 2 cycles.
- Divide-by-zero: stall for exactly 1 cycle; DONE at N+1.
- Back-to-back ops: DONE→IDLE on ex_accept. The next op launches in the following cycle. No start edge is lost, because start is low for at least one cycle (DONE).
- Outputs are registered except stallreq, hi_we and lo_we, which are decoded from state.

## Test plan
- MULT: src1=-3 (32'hFFFF_FFFD), src2=7, mul_ready after 32 cycles → mul_signed=1 throughout BUSY; DONE gives hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB; stallreq high 33 cycles total.
- DIVU: src1=100, src2=7, div_ready after 34 cycles → div_signed=0; lo=14, hi=2; one write when ex_accept=1.
- DIV by zero: src1=32'h1234, src2=0 → div_start never asserted; next cycle hi=32'h1234, lo=32'hFFFF_FFFF; stallreq for 1 cycle.
- Flush in BUSY cycle 10 of a MULTU → mul_annul pulses 1 cycle; IDLE next; hi_we never asserted; a new DIVU the following cycle launches normally.
- Watchdog: TIMEOUT=64, ready never returned → annul pulse at BUSY cycle 64; timeout_err=1 and stays set; hi=lo=0 written; rst clears timeout_err.
- Back-to-back MULT then MULTU with identical operands → two distinct start assertions separated by ≥1 low cycle; two HI/LO writes.
